qos_sched: RTL and testbench

QOS_SCHED -- requirements
Module: qos_sched

---
 rtl/qos_sched.sv | 214 +++++++++++++++++++++
 tb/tb_qos_sched.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/qos_sched.sv
// qos_sched: CPU bus QoS throttle for a shared-RAM system.
//
// The CPU gets a budget of CREDMAX bus-cycle starts per credit window of
// WINDOW SlowTick strobes. When the budget is exhausted and a video/sound
// fetch is pending, the scheduler enters THROT. In THROT, QoSEN holds off
// the CPU's RAM/ROM DTACK. It leaves THROT through a fixed two-cycle DRAIN
// state and then returns to RUN.
//
// Optional feature (macro QOS_IOFORCE_EN):
//   A cycle start with IOCS=1 loads a 3-bit IO hold counter with 7. The
//   counter then counts down on SlowTick. While it is nonzero, the
//   scheduler is forced into THROT and may not exit THROT.
//   When the macro is undefined, IOCS is ignored and no hold logic exists.
module qos_sched #(
  parameter int unsigned CREDMAX = 12,  // credits per window, 1..15
  parameter int unsigned WINDOW  = 48   // SlowTicks per window, 2..63
) (
  input  logic       FCLK,
  input  logic       RST,
  input  logic       BACT,
  input  logic       IOCS,
  input  logic       DMAPend,
  input  logic       SlowTick,
  output logic       QoSEN,
  output logic [3:0] Credit,
  output logic       Throttling
);

  localparam logic [3:0] CRED_INIT = 4'(CREDMAX);
  localparam logic [5:0] WIN_LAST  = 6'(WINDOW - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_THROT = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Cycle-start detection: the rising edge of BACT marks one AS cycle.
  // ---------------------------------------------------------------------
  logic bact_q;
  logic cyc_start;

  assign cyc_start = BACT & ~bact_q;

  // Delay BACT by one FCLK so that its rising edge can be detected.
  always_ff @(posedge FCLK) begin
    if (RST) begin
      bact_q <= 1'b0;
    end else begin
      bact_q <= BACT;
    end
  end

  // ---------------------------------------------------------------------
  // Credit window counter: wraps after WINDOW SlowTicks and pulses reload.
  // ---------------------------------------------------------------------
  logic [5:0] wcnt_q, wcnt_d;
  logic       reload;

  // Advance the window on each SlowTick; the terminal tick wraps to 0 and
  // raises reload for that same cycle.
  always_comb begin
    wcnt_d = wcnt_q;
    reload = 1'b0;
    if (SlowTick) begin
      if (wcnt_q == WIN_LAST) begin
        wcnt_d = 6'd0;
        reload = 1'b1;
      end else begin
        wcnt_d = wcnt_q + 6'd1;
      end
    end
  end

  // Window counter register.
  always_ff @(posedge FCLK) begin
    if (RST) begin
      wcnt_q <= 6'd0;
    end else begin
      wcnt_q <= wcnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Credit counter: refilled on reload, otherwise spent by cycle starts.
  // ---------------------------------------------------------------------
  logic [3:0] credit_q, credit_d;

  // Reload wins over a coincident cycle start. Spending saturates at zero.
  always_comb begin
    credit_d = credit_q;
    if (reload) begin
      credit_d = CRED_INIT;
    end else if (cyc_start && (credit_q != 4'd0)) begin
      credit_d = credit_q - 4'd1;
    end
  end

  // Credit register.
  always_ff @(posedge FCLK) begin
    if (RST) begin
      credit_q <= CRED_INIT;
    end else begin
      credit_q <= credit_d;
    end
  end

  // ---------------------------------------------------------------------
  // Optional IO hold: slow I/O accesses force a throttle period.
  // ---------------------------------------------------------------------
  logic io_force;  // hold active: push RUN into THROT
  logic io_clear;  // hold expired: THROT may exit

`ifdef QOS_IOFORCE_EN
  logic [2:0] io_hold_q, io_hold_d;

  // A new IO cycle start reloads the hold. Otherwise the hold counts down
  // on each SlowTick until it reaches zero.
  always_comb begin
    io_hold_d = io_hold_q;
    if (cyc_start && IOCS) begin
      io_hold_d = 3'd7;
    end else if (SlowTick && (io_hold_q != 3'd0)) begin
      io_hold_d = io_hold_q - 3'd1;
    end
  end

  // IO hold counter register.
  always_ff @(posedge FCLK) begin
    if (RST) begin
      io_hold_q <= 3'd0;
    end else begin
      io_hold_q <= io_hold_d;
    end
  end

  assign io_force = (io_hold_q != 3'd0);
  assign io_clear = (io_hold_q == 3'd0);
`else
  // IOCS has no function in this build; it is tied off here only so that
  // it is not left dangling.
  logic iocs_unused;
  assign iocs_unused = IOCS;
  assign io_force    = 1'b0;
  assign io_clear    = 1'b1;
`endif

  // ---------------------------------------------------------------------
  // Throttle FSM.
  // ---------------------------------------------------------------------
  state_t state_q, state_d;
  logic   drain_cnt_q, drain_cnt_d;  // marks the second DRAIN cycle
  logic   throt_d;
  logic   qosen_q;
  logic   throttling_q;

  // Next-state logic. RUN enters THROT only while BACT is low, so QoSEN
  // never rises in the middle of a CPU cycle. DRAIN always lasts exactly
  // two cycles; a reload during DRAIN only refills credit.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (!BACT && (((credit_q == 4'd0) && DMAPend) || io_force)) begin
          state_d = ST_THROT;
        end
      end
      ST_THROT: begin
        if ((reload || !DMAPend) && io_clear) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q) begin
          state_d     = ST_RUN;
          drain_cnt_d = 1'b0;
        end else begin
          drain_cnt_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_RUN;
        drain_cnt_d = 1'b0;
      end
    endcase
  end

  // Both outputs are registered from the next state. They therefore change
  // on the same edge as the state transition.
  assign throt_d = (state_d != ST_RUN);

  // State and registered-output update.
  always_ff @(posedge FCLK) begin
    if (RST) begin
      state_q      <= ST_RUN;
      drain_cnt_q  <= 1'b0;
      qosen_q      <= 1'b0;
      throttling_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_cnt_q  <= drain_cnt_d;
      qosen_q      <= throt_d;
      throttling_q <= throt_d;
    end
  end

  assign QoSEN      = qosen_q;
  assign Throttling = throttling_q;
  assign Credit     = credit_q;

endmodule

// File: tb/tb_qos_sched.sv
// Directed, scoreboard-based testbench for qos_sched (default parameters).
// Stimulus pushes the expected registered outputs after each clock edge.
// An independent monitor pops those entries on the falling edge and
// compares them with the DUT outputs.
module tb_qos_sched;

  logic       FCLK = 1'b0;
  logic       RST = 1'b0;
  logic       BACT = 1'b0;
  logic       IOCS = 1'b0;
  logic       DMAPend = 1'b0;
  logic       SlowTick = 1'b0;
  logic       QoSEN;
  logic [3:0] Credit;
  logic       Throttling;

  qos_sched #(.CREDMAX(12), .WINDOW(48)) dut (
    .FCLK      (FCLK),
    .RST       (RST),
    .BACT      (BACT),
    .IOCS      (IOCS),
    .DMAPend   (DMAPend),
    .SlowTick  (SlowTick),
    .QoSEN     (QoSEN),
    .Credit    (Credit),
    .Throttling(Throttling)
  );

  always #5 FCLK = ~FCLK;

  typedef struct {
    string      name;
    logic       qosen;
    logic [3:0] credit;
    logic       throt;
  } exp_t;

  exp_t exp_q[$];
  int   n_compared = 0;
  int   n_failed = 0;

  // Advance one clock edge; the outputs then reflect that edge.
  task automatic step();
    @(posedge FCLK);
    #1;
  endtask

  task automatic expect_out(input string name, input logic q,
                            input logic [3:0] c, input logic t);
    exp_t e;
    e.name   = name;
    e.qosen  = q;
    e.credit = c;
    e.throt  = t;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every pending expectation at the falling edge.
  always @(negedge FCLK) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_compared++;
      if (QoSEN !== e.qosen || Credit !== e.credit || Throttling !== e.throt) begin
        n_failed++;
        $display("FAIL %s: got QoSEN=%0b Credit=%0d Throttling=%0b, want QoSEN=%0b Credit=%0d Throttling=%0b",
                 e.name, QoSEN, Credit, Throttling, e.qosen, e.credit, e.throt);
      end else begin
        $display("ok   %s: QoSEN=%0b Credit=%0d Throttling=%0b",
                 e.name, QoSEN, Credit, Throttling);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    RST = 1'b1;
    step();
    expect_out("reset", 1'b0, 4'd12, 1'b0);
    RST = 1'b0;

    // Twelve cycle starts with a pending fetch drain the credit to zero.
    DMAPend = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      BACT = 1'b1;
      step();
      expect_out($sformatf("start%0d", k), 1'b0, 4'(12 - k), 1'b0);
      BACT = 1'b0;
      step();
      if (k < 12) expect_out($sformatf("idle%0d", k), 1'b0, 4'(12 - k), 1'b0);
      else        expect_out("throt_rise", 1'b1, 4'd0, 1'b1);
    end

    // A further cycle start in THROT saturates the credit at zero.
    BACT = 1'b1;
    step();
    expect_out("saturate", 1'b1, 4'd0, 1'b1);
    BACT = 1'b0;
    step();
    expect_out("saturate_idle", 1'b1, 4'd0, 1'b1);

    // A window of 48 SlowTicks reloads credit and enters DRAIN for 2 cycles.
    SlowTick = 1'b1;
    for (int k = 1; k <= 47; k++) step();
    expect_out("tick47", 1'b1, 4'd0, 1'b1);
    step();
    expect_out("reload_drain1", 1'b1, 4'd12, 1'b1);
    SlowTick = 1'b0;
    step();
    expect_out("drain2", 1'b1, 4'd12, 1'b1);
    step();
    expect_out("run_after_drain", 1'b0, 4'd12, 1'b0);

    // A cycle start coincident with reload leaves the credit at 12.
    SlowTick = 1'b1;
    for (int k = 1; k <= 47; k++) step();
    BACT = 1'b1;
    step();
    expect_out("start_on_reload", 1'b0, 4'd12, 1'b0);
    BACT = 1'b0;
    SlowTick = 1'b0;
    step();
    BACT = 1'b1;
    step();
    expect_out("start_after_reload", 1'b0, 4'd11, 1'b0);
    BACT = 1'b0;
    step();

    // Drain credit with no fetch pending; no throttling occurs.
    DMAPend = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      BACT = 1'b1;
      step();
      BACT = 1'b0;
      step();
    end
    expect_out("drained_no_dma", 1'b0, 4'd0, 1'b0);

    // DMAPend rises while BACT=1: the throttle waits for BACT to fall.
    BACT = 1'b1;
    step();
    DMAPend = 1'b1;
    step();
    expect_out("dma_bact_hi1", 1'b0, 4'd0, 1'b0);
    step();
    expect_out("dma_bact_hi2", 1'b0, 4'd0, 1'b0);
    BACT = 1'b0;
    step();
    expect_out("bact_fell", 1'b1, 4'd0, 1'b1);

    // Advance the window a little in THROT, then DMAPend drops into DRAIN.
    SlowTick = 1'b1;
    for (int k = 1; k <= 5; k++) step();
    SlowTick = 1'b0;
    expect_out("throt_ticks", 1'b1, 4'd0, 1'b1);
    DMAPend = 1'b0;
    step();
    expect_out("dma_drop_drain", 1'b1, 4'd0, 1'b1);

    // Reset in DRAIN, with BACT high, counts no cycle start.
    RST = 1'b1;
    BACT = 1'b1;
    step();
    expect_out("reset_in_drain", 1'b0, 4'd12, 1'b0);
    RST = 1'b0;
    step();
    expect_out("start_after_reset", 1'b0, 4'd11, 1'b0);
    BACT = 1'b0;
    step();

    // The window counter restarted at 0: 47 ticks give no reload, tick 48 does.
    SlowTick = 1'b1;
    for (int k = 1; k <= 47; k++) step();
    expect_out("wcnt_reset_47", 1'b0, 4'd11, 1'b0);
    step();
    expect_out("wcnt_reset_48", 1'b0, 4'd12, 1'b0);
    SlowTick = 1'b0;

    // IO-space cycle start with no fetch pending.
    IOCS = 1'b1;
    BACT = 1'b1;
    step();
    expect_out("io_start", 1'b0, 4'd11, 1'b0);
    IOCS = 1'b0;
    BACT = 1'b0;
    step();
`ifdef QOS_IOFORCE_EN
    expect_out("io_throt", 1'b1, 4'd11, 1'b1);
    SlowTick = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      expect_out($sformatf("io_tick%0d", k), 1'b1, 4'd11, 1'b1);
    end
    SlowTick = 1'b0;
    step();
    expect_out("io_drain1", 1'b1, 4'd11, 1'b1);
    step();
    expect_out("io_drain2", 1'b1, 4'd11, 1'b1);
    step();
    expect_out("io_run", 1'b0, 4'd11, 1'b0);
`else
    expect_out("io_ignored", 1'b0, 4'd11, 1'b0);
    SlowTick = 1'b1;
    for (int k = 1; k <= 7; k++) step();
    SlowTick = 1'b0;
    expect_out("io_ignored_ticks", 1'b0, 4'd11, 1'b0);
    step();
    step();
    step();
`endif
    step();
    expect_out("final_idle", 1'b0, 4'd11, 1'b0);

    @(negedge FCLK);
    #1;
    if (exp_q.size() != 0) begin
      n_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
